pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 16-bit five-stage pipeline. Each cycle it decides which pipeline registers advance, which load a NOP bubble, and whether the PC updates. It covers load-use hazards, taken-branch squash, multi-cycle memory waits and HALT. It drives the RegWrite and flush inputs of IF_ID, ID_EX, EX_MEM and MEM_WB and the PC write enable.

---
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_W = 3
);
  logic [REG_W-1:0] ID_Rs1;
  logic [REG_W-1:0] ID_Rs2;
  logic             ID_UsesRs1;
  logic             ID_UsesRs2;
  logic [REG_W-1:0] EX_Rd;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic             EX_BranchTaken;
  logic             MEM_Access;
  logic             WB_Halt;
  logic             PCWrite;
  logic             IF_ID_RegWrite;
  logic             ID_EX_RegWrite;
  logic             EX_MEM_RegWrite;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             MEM_WB_Flush;
  logic             Stalled;
  logic             Halted;

  modport master (
    output ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_Rd, EX_MemRead, EX_RegWrite,
           EX_BranchTaken, MEM_Access, WB_Halt,
    input  PCWrite, IF_ID_RegWrite, ID_EX_RegWrite, EX_MEM_RegWrite, IF_ID_Flush,
           ID_EX_Flush, MEM_WB_Flush, Stalled, Halted
  );

  modport slave (
    input  ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, EX_Rd, EX_MemRead, EX_RegWrite,
           EX_BranchTaken, MEM_Access, WB_Halt,
    output PCWrite, IF_ID_RegWrite, ID_EX_RegWrite, EX_MEM_RegWrite, IF_ID_Flush,
           ID_EX_Flush, MEM_WB_Flush, Stalled, Halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, taken-branch
// squash, multi-cycle memory freeze and HALT.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned REG_W   = 3
) (
  input logic                   CLK,
  input logic                   Reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

  localparam logic [3:0] CntLoad = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic pc_write, if_id_we, id_ex_we, ex_mem_we;
  logic if_id_flush, id_ex_flush, mem_wb_flush, stalled, halted;
  logic waiting, releasing, mem_start, halt_now, load_use;

  always_comb begin
    waiting   = (state_q == StMemWait) && (cnt_q != 4'd0);
    releasing = (state_q == StMemWait) && (cnt_q == 4'd0);
    // The completing access is still in MEM during release; don't restart it.
    mem_start = (state_q == StRun) && bus.MEM_Access && (MEM_LAT > 1);
    halt_now  = bus.WB_Halt && ((state_q == StRun) || releasing);
    load_use  = bus.EX_MemRead && bus.EX_RegWrite && (bus.EX_Rd != '0) &&
                ((bus.ID_UsesRs1 && (bus.ID_Rs1 == bus.EX_Rd)) ||
                 (bus.ID_UsesRs2 && (bus.ID_Rs2 == bus.EX_Rd)));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    stalled      = 1'b0;
    halted       = 1'b0;
    if (Reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = StRun;
      cnt_d        = 4'd0;
    end else if (state_q == StHalted) begin
      halted  = 1'b1;
      stalled = 1'b1;
    end else if (waiting || mem_start || halt_now) begin
      mem_wb_flush = 1'b1;
      stalled      = 1'b1;
      if (halt_now) begin
        state_d = StHalted;
      end else if (waiting) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = StMemWait;
        cnt_d   = CntLoad;
      end
    end else begin
      pc_write  = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      state_d   = StRun;
      cnt_d     = 4'd0;
      if (bus.EX_BranchTaken) begin
        // Squashing the ID instruction also removes any load-use on it.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        stalled     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PCWrite         = pc_write;
  assign bus.IF_ID_RegWrite  = if_id_we;
  assign bus.ID_EX_RegWrite  = id_ex_we;
  assign bus.EX_MEM_RegWrite = ex_mem_we;
  assign bus.IF_ID_Flush     = if_id_flush;
  assign bus.ID_EX_Flush     = id_ex_flush;
  assign bus.MEM_WB_Flush    = mem_wb_flush;
  assign bus.Stalled         = stalled;
  assign bus.Halted          = halted;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against a cycle-count reference model (MEM_LAT=3 and MEM_LAT=1).
module tb_pipeline_hazard_ctrl;
  // Output vector order:
  // {PCWrite, IF_ID_RW, ID_EX_RW, EX_MEM_RW, IF_ID_Fl, ID_EX_Fl, MEM_WB_Fl, Stalled, Halted}
  localparam logic [8:0] VRst = 9'b0000_111_00;
  localparam logic [8:0] VNrm = 9'b1111_000_00;
  localparam logic [8:0] VBr  = 9'b1111_110_00;
  localparam logic [8:0] VLu  = 9'b0011_010_10;
  localparam logic [8:0] VFrz = 9'b0000_001_10;
  localparam logic [8:0] VHlt = 9'b0000_000_11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rs1, rs2, rd;
  logic       u1, u2, mr, rw, br, mem, halt;

  pipeline_hazard_ctrl_if #(.REG_W(3)) bus3 ();
  pipeline_hazard_ctrl_if #(.REG_W(3)) bus1 ();

  assign bus3.ID_Rs1 = rs1;         assign bus1.ID_Rs1 = rs1;
  assign bus3.ID_Rs2 = rs2;         assign bus1.ID_Rs2 = rs2;
  assign bus3.ID_UsesRs1 = u1;      assign bus1.ID_UsesRs1 = u1;
  assign bus3.ID_UsesRs2 = u2;      assign bus1.ID_UsesRs2 = u2;
  assign bus3.EX_Rd = rd;           assign bus1.EX_Rd = rd;
  assign bus3.EX_MemRead = mr;      assign bus1.EX_MemRead = mr;
  assign bus3.EX_RegWrite = rw;     assign bus1.EX_RegWrite = rw;
  assign bus3.EX_BranchTaken = br;  assign bus1.EX_BranchTaken = br;
  assign bus3.MEM_Access = mem;     assign bus1.MEM_Access = mem;
  assign bus3.WB_Halt = halt;       assign bus1.WB_Halt = halt;

  pipeline_hazard_ctrl #(.MEM_LAT(3), .REG_W(3)) dut3 (.CLK(clk), .Reset(rst), .bus(bus3));
  pipeline_hazard_ctrl #(.MEM_LAT(1), .REG_W(3)) dut1 (.CLK(clk), .Reset(rst), .bus(bus1));

  wire [8:0] out3 = {bus3.PCWrite, bus3.IF_ID_RegWrite, bus3.ID_EX_RegWrite,
                     bus3.EX_MEM_RegWrite, bus3.IF_ID_Flush, bus3.ID_EX_Flush,
                     bus3.MEM_WB_Flush, bus3.Stalled, bus3.Halted};
  wire [8:0] out1 = {bus1.PCWrite, bus1.IF_ID_RegWrite, bus1.ID_EX_RegWrite,
                     bus1.EX_MEM_RegWrite, bus1.IF_ID_Flush, bus1.ID_EX_Flush,
                     bus1.MEM_WB_Flush, bus1.Stalled, bus1.Halted};

  int total = 0;
  int bad   = 0;

  // Reference model: freeze cycles still owed, a pending release, and a halt flag.
  int unsigned lat[2] = '{3, 1};
  int          owed[2] = '{0, 0};
  bit          rel_next[2] = '{1'b0, 1'b0};
  bit          m_halted[2] = '{1'b0, 1'b0};

  task automatic model(input int k, output logic [8:0] o);
    bit is_rel, lu;
    lu = mr && rw && (rd != 3'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst) begin
      o = VRst; owed[k] = 0; rel_next[k] = 1'b0; m_halted[k] = 1'b0;
    end else if (m_halted[k]) begin
      o = VHlt;
    end else if (owed[k] > 0) begin
      o = VFrz;
      owed[k]--;
      if (owed[k] == 0) rel_next[k] = 1'b1;
    end else begin
      is_rel = rel_next[k];
      rel_next[k] = 1'b0;
      if (halt) begin
        o = VFrz; m_halted[k] = 1'b1;
      end else if (!is_rel && mem && lat[k] > 1) begin
        // Access lasts lat-1 freeze cycles; this is the first of them.
        o = VFrz;
        owed[k] = int'(lat[k]) - 2;
        if (owed[k] == 0) rel_next[k] = 1'b1;
      end else if (br) o = VBr;
      else if (lu) o = VLu;
      else o = VNrm;
    end
  endtask

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Called at a negedge with inputs applied; compares, advances the model, waits a cycle.
  task automatic step(input string nm, input logic [8:0] e3, input bit c3,
                      input logic [8:0] e1, input bit c1, input bit use_model);
    logic [8:0] m3, m1;
    #1;
    model(0, m3);
    model(1, m1);
    if (use_model) begin
      check({nm, "/lat3"}, out3, m3);
      check({nm, "/lat1"}, out1, m1);
    end else begin
      if (c3) check(nm, out3, e3);
      if (c1) check({nm, "/lat1"}, out1, e1);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rs1 = 3'd1; rs2 = 3'd2; u1 = 0; u2 = 0; rd = 3'd3;
    mr = 0; rw = 0; br = 0; mem = 0; halt = 0;
  endtask

  typedef struct {
    logic [2:0] rs1, rs2;
    logic       u1, u2;
    logic [2:0] rd;
    logic       mr, rw, br;
    logic [8:0] exp;
    string      nm;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{3'd1, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, VNrm, "no_match"};
    tbl[1] = '{3'd1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, VLu,  "lu_rs2"};
    tbl[2] = '{3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, VNrm, "lu_r0"};
    tbl[3] = '{3'd1, 3'd3, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, VNrm, "lu_unused"};
    tbl[4] = '{3'd6, 3'd2, 1'b1, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0, VLu,  "lu_rs1"};
    tbl[5] = '{3'd1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, VBr,  "br_plus_lu"};
    tbl[6] = '{3'd1, 3'd2, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, VBr,  "br_only"};
    tbl[7] = '{3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, VNrm, "ld_no_wr"};
    tbl[8] = '{3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, VNrm, "no_load"};

    idle();
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      rs1 = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom);
      u1 = 1'($urandom); u2 = 1'($urandom); mr = 1'($urandom); rw = 1'($urandom);
      br = 1'($urandom); mem = 1'($urandom); halt = 1'($urandom);
      step("reset", VRst, 1, VRst, 1, 0);
    end
    idle();
    step("post_reset", VNrm, 1, VNrm, 1, 0);

    for (int i = 0; i < 9; i++) begin
      idle();
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; u1 = tbl[i].u1; u2 = tbl[i].u2;
      rd = tbl[i].rd; mr = tbl[i].mr; rw = tbl[i].rw; br = tbl[i].br;
      step(tbl[i].nm, tbl[i].exp, 1, tbl[i].exp, 1, 0);
    end

    // Held memory access: two freezes then release; MEM_LAT=1 never freezes.
    idle(); mem = 1;
    step("mem_frz0", VFrz, 1, VNrm, 1, 0);
    step("mem_frz1", VFrz, 1, VNrm, 1, 0);
    step("mem_release", VNrm, 1, VNrm, 1, 0);
    step("mem_again", VFrz, 1, VNrm, 1, 0);
    idle();
    step("mem_again_frz", VFrz, 1, VNrm, 0, 0);
    step("mem_again_rel", VNrm, 1, VNrm, 0, 0);

    // Branch during freeze is only acted on at release.
    idle(); mem = 1;
    step("br_wait0", VFrz, 1, VNrm, 0, 0);
    mem = 0; br = 1;
    step("br_wait1", VFrz, 1, VNrm, 0, 0);
    step("br_release", VBr, 1, VNrm, 0, 0);

    // HALT then reset recovery.
    idle(); halt = 1;
    step("halt_frz", VFrz, 1, VFrz, 1, 0);
    halt = 0;
    for (int i = 0; i < 5; i++) step("halted", VHlt, 1, VHlt, 1, 0);
    rst = 1;
    step("halt_reset", VRst, 1, VRst, 1, 0);
    rst = 0;
    step("halt_run", VNrm, 1, VNrm, 1, 0);

    // Reset mid-wait leaves no residual freeze.
    mem = 1;
    step("rmw_frz", VFrz, 1, VNrm, 0, 0);
    mem = 0; rst = 1;
    step("rmw_reset", VRst, 1, VRst, 0, 0);
    rst = 0;
    step("rmw_run0", VNrm, 1, VNrm, 0, 0);
    step("rmw_run1", VNrm, 1, VNrm, 0, 0);

    // HALT arriving in the release cycle freezes instead of releasing.
    mem = 1;
    step("hr_frz0", VFrz, 1, VNrm, 0, 0);
    mem = 0;
    step("hr_frz1", VFrz, 1, VNrm, 0, 0);
    halt = 1;
    step("hr_release_halt", VFrz, 1, VFrz, 0, 0);
    halt = 0;
    step("hr_halted", VHlt, 1, VHlt, 0, 0);
    rst = 1;
    step("hr_reset", VRst, 1, VRst, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 19) == 0);
      halt = ($urandom_range(0, 24) == 0);
      mem  = ($urandom_range(0, 2) == 0);
      br   = ($urandom_range(0, 3) == 0);
      mr   = 1'($urandom); rw = 1'($urandom);
      u1   = 1'($urandom); u2 = 1'($urandom);
      rs1  = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom_range(0, 3));
      step("rand", 9'd0, 0, 9'd0, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
